// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the multiply sequencer: default widths, HI/LO
// select encoding and the sequencer state encoding.
package mult_sequencer_pkg;

  localparam int MS_WIDTH = 32;
  localparam int MS_ITER  = MS_WIDTH;

  localparam logic MT_SEL_LO = 1'b0;
  localparam logic MT_SEL_HI = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    LOAD    = ST_LOAD,
    RUN     = ST_RUN,
    CAPTURE = ST_CAPTURE
  } state_e;

endpackage

// File: rtl/mult_sequencer.sv
// Drives an external iterative shift-add multiplier through load + ITER
// iterations, then captures the product into the HI/LO register pair.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = MS_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             mult_ctrl,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // An MT write and a start in the same cycle both take effect; the
        // product later overwrites HI/LO at capture.
        if (mt_we) begin
          if (mt_sel == MT_SEL_HI) hi_d = mt_data;
          else                     lo_d = mt_data;
        end
        if (start) begin
          state_d = LOAD;
          a_d     = op_a;
          b_d     = op_b;
        end
      end
      LOAD: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) state_d = CAPTURE;
      end
      CAPTURE: begin
        hi_d    = mult_hi;
        lo_d    = mult_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign mult_a    = a_q;
  assign mult_b    = b_q;
  assign mult_ctrl = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign stall     = busy & (mf_req | mt_we | start);
  assign done      = done_q;
  assign rd_data   = (mt_sel == MT_SEL_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed + randomized bench for mult_sequencer with a behavioural
// iterative multiplier and a HI/LO reference model.
module tb_mult_sequencer;

  localparam int W    = 32;
  localparam int ITER = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic [W-1:0] mult_a, mult_b;
  logic         mult_ctrl;
  logic [W-1:0] mult_hi, mult_lo;
  logic         mt_we, mt_sel;
  logic [W-1:0] mt_data;
  logic         mf_req;
  logic [W-1:0] rd_data;
  logic         busy, stall, done;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W), .ITER(ITER)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_ctrl(mult_ctrl),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .mt_we(mt_we), .mt_sel(mt_sel),
    .mt_data(mt_data), .mf_req(mf_req), .rd_data(rd_data),
    .busy(busy), .stall(stall), .done(done)
  );

  function automatic logic [63:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Multiplier environment: product is only correct after exactly ITER
  // iterations following a load; any other count yields a corrupted value.
  logic [W-1:0] m_a = '0, m_b = '0;
  int           m_cnt = 0;
  always @(posedge clk) begin
    if (mult_ctrl) begin
      m_a   <= mult_a;
      m_b   <= mult_b;
      m_cnt <= 0;
    end else if (m_cnt < 1000) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign {mult_hi, mult_lo} = (m_cnt == ITER) ? smul(m_a, m_b) : ~smul(m_a, m_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input string tag);
    mt_sel = 1'b1; #1;
    check({tag, "_hi"}, rd_data, exp_hi);
    mt_sel = 1'b0; #1;
    check({tag, "_lo"}, rd_data, exp_lo);
  endtask

  // Caller has start=1 and operands driven in an IDLE cycle (edge 0 next).
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                          input int mt_at, input logic [W-1:0] mt_val,
                          input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [63:0] p;
    p = smul(a, b);
    tick();
    start = 1'b0;
    if (mt_we) begin
      mt_we = 1'b0;
      if (mt_sel) exp_hi = mt_data; else exp_lo = mt_data;
    end
    #1;
    check("load_ctrl", mult_ctrl, 1'b1);
    check("load_busy", busy, 1'b1);
    check("load_stall", stall, 1'b0);
    check("load_a", mult_a, a);
    check("load_b", mult_b, b);
    check("busy_rd_old", rd_data, mt_sel ? exp_hi : exp_lo);
    for (int c = 2; c <= ITER + 2; c++) begin
      tick();
      start  = 1'b0;
      mf_req = 1'b0;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        mf_req = 1'($urandom_range(0, 1));
        op_a   = $urandom;
        op_b   = $urandom;
      end
      if (mt_at != 0 && c == mt_at) begin
        mt_we = 1'b1; mt_sel = 1'b1; mt_data = mt_val;
      end
      #1;
      check("run_ctrl", mult_ctrl, 1'b0);
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      check("run_stall", stall, start | mt_we | mf_req);
      check("run_a", mult_a, a);
      check("run_b", mult_b, b);
    end
    tick();
    start  = 1'b0;
    mf_req = 1'b0;
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    #1;
    $display("mult a=%h b=%h expect hi=%h lo=%h", a, b, exp_hi, exp_lo);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_stall", stall, 1'b0);
    check_rd("product");
    if (mt_we) begin
      mt_sel = 1'b1;
      exp_hi = mt_data;
    end
    if (chain) begin
      start = 1'b1; op_a = na; op_b = nb;
    end else begin
      tick();
      mt_we = 1'b0;
      #1;
      check("done_clear", done, 1'b0);
      check_rd("after");
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc, rd2;
    reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0; mf_req = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_ctrl", mult_ctrl, 1'b0);
    check("rst_a", mult_a, '0);
    check("rst_b", mult_b, '0);
    check_rd("rst");
    #10 reset = 1'b1;
    tick();

    // Reset asserted in cycle 10 (mid-RUN) aborts without any HI/LO update.
    start = 1'b1; op_a = 32'd7; op_b = 32'd6;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_abort_busy", busy, 1'b1);
    #2 reset = 1'b0; #1;
    check("abort_busy", busy, 1'b0);
    check("abort_ctrl", mult_ctrl, 1'b0);
    check("abort_a", mult_a, '0);
    check("abort_b", mult_b, '0);
    check("abort_done", done, 1'b0);
    check_rd("abort");
    repeat (3) tick();
    #2 reset = 1'b1;
    for (int i = 0; i < ITER + 6; i++) begin
      tick();
      check("abort_no_done", done, 1'b0);
    end
    check_rd("abort_end");

    // Directed products.
    start = 1'b1; op_a = 32'd7; op_b = 32'd6;
    run_mult(32'd7, 32'd6, 1'b0, 0, '0, 1'b0, '0, '0);
    start = 1'b1; op_a = 32'hFFFF_FFFD; op_b = 32'd5;
    run_mult(32'hFFFF_FFFD, 32'd5, 1'b0, 0, '0, 1'b0, '0, '0);
    start = 1'b1; op_a = 32'h8000_0000; op_b = 32'h8000_0000;
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b0, 0, '0, 1'b0, '0, '0);

    // MT write to HI issued in cycle 5, held until it lands after done.
    ra = $urandom; rb = $urandom;
    start = 1'b1; op_a = ra; op_b = rb;
    run_mult(ra, rb, 1'b0, 5, 32'hDEAD_BEEF, 1'b0, '0, '0);

    // Plain MT write to LO while idle.
    rc = $urandom;
    mt_we = 1'b1; mt_sel = 1'b0; mt_data = rc;
    tick();
    mt_we = 1'b0;
    exp_lo = rc;
    check_rd("mt_idle");

    // Start and MT write together: write lands, product later overwrites.
    ra = $urandom; rb = $urandom; rc = $urandom;
    start = 1'b1; op_a = ra; op_b = rb;
    mt_we = 1'b1; mt_sel = 1'b0; mt_data = rc;
    run_mult(ra, rb, 1'b0, 0, '0, 1'b0, '0, '0);

    // Back-to-back with ignored start pulses during RUN.
    ra = $urandom; rb = $urandom; rc = $urandom; rd2 = $urandom;
    start = 1'b1; op_a = ra; op_b = rb;
    run_mult(ra, rb, 1'b1, 0, '0, 1'b1, rc, rd2);
    run_mult(rc, rd2, 1'b1, 0, '0, 1'b0, '0, '0);

    // Randomized operands with request noise.
    for (int n = 0; n < 6; n++) begin
      ra = $urandom; rb = $urandom;
      if (n == 0) rb = 32'hFFFF_FFFF;
      start = 1'b1; op_a = ra; op_b = rb;
      run_mult(ra, rb, 1'b1, 0, '0, 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Sequencer and HI/LO architectural register pair that sits directly downstream of the iterative shift-add multiplier. It captures an operand pair on a start request and drives the multiplier's load/iterate control through exactly `ITER` iteration cycles. It writes the 64-bit product into HI and LO and signals completion. It also serves MTHI/MTLO writes and MFHI/MFLO reads, and stalls them while a multiply is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO register width.
- `ITER`, `WIDTH`: multiplier iteration cycles (one product bit per cycle).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a multiply; accepted only in IDLE.
- `op_a`, `op_b`  in  `WIDTH`  signed operands; sampled on the accepting edge.
- `mult_a`, `mult_b`  out  `WIDTH`  latched operands to the multiplier's `srcA`/`srcB`.
- `mult_ctrl`  out  1  to the multiplier's `multCtrl`: 1 = load, 0 = iterate.
- `mult_hi`, `mult_lo`  in  `WIDTH`  product halves from the multiplier.
- `mt_we`  in  1  MTHI/MTLO write request.
- `mt_sel`  in  1  0 = LO, 1 = HI (for both write and read).
- `mt_data`  in  `WIDTH`  write data.
- `mf_req`  in  1  MFHI/MFLO read request.
- `rd_data`  out  `WIDTH`  selected HI or LO; combinational from the registers.
- `busy`  out  1  high in LOAD, RUN and CAPTURE.
- `stall`  out  1  `busy & (mf_req | mt_we | start)`.
- `done`  out  1  one-cycle pulse after HI/LO update.

## Operation
- States:
  - IDLE: `start` → LOAD and latch `op_a`/`op_b` into `mult_a`/`mult_b`.
  - LOAD: `mult_ctrl`=1 for exactly one cycle; → RUN with the counter cleared.
  - RUN: `mult_ctrl`=0; the counter increments each cycle; on count `ITER-1` → CAPTURE.
  - CAPTURE: HI←`mult_hi`, LO←`mult_lo` on the exit edge; → IDLE, and `done`=1 for the following cycle.
- `mult_ctrl` is 0 in IDLE and CAPTURE. The multiplier iterates harmlessly then, because its result is overwritten by the next load.
- `mult_a`/`mult_b` are held stable from LOAD through CAPTURE.
- MT write:
  - Performed on the edge when `mt_we` is high and the state is IDLE.
  - Ignored when busy; `stall` stays high until IDLE, and the requester holds the request.
- `start` while busy is ignored; `stall` is high and operands are not re-latched.
- `start` together with `mt_we` in IDLE: both are performed. The MT write lands immediately and the product overwrites HI and LO at CAPTURE.
- MF read:
  - `rd_data` is always driven.
  - While busy it shows the old HI/LO and `stall` is high; the consumer must not use it.
- Width rules:
  - The product is 2·`WIDTH` bits, two's complement.
  - HI holds bits [2W-1:W] and LO holds [W-1:0], with no truncation or saturation.
  - Counter width is clog2(`ITER`)+1; it never wraps inside RUN.

## Timing
- Reset (async assert, sync release): state = IDLE, counter = 0, HI = LO = 0, `mult_a` = `mult_b` = 0, `mult_ctrl` = 0, `busy` = `stall` = `done` = 0.
- Reset mid-operation aborts immediately, with no HI/LO update and no `done`.
- Latency, with edge 0 as the edge that accepts `start`:
  - Cycle 1 is LOAD; the multiplier loads at edge 1.
  - Cycles 2..`ITER`+1 are RUN; iterations happen at edges 2..`ITER`+1.
  - Cycle `ITER`+2 is CAPTURE; HI and LO are written at edge `ITER`+2.
  - `done`=1 and new HI/LO are visible in cycle `ITER`+3 (35 for `ITER`=32).
- `busy` rises in cycle 1 and falls in cycle `ITER`+3.
- Back-to-back: a `start` held high in the `done` cycle is accepted at that cycle's edge.
- Minimum issue interval: `ITER`+3 cycles.
- `done` and `busy` are registered; `stall` and `rd_data` are combinational.

## Structure
- Shared package:
  - state enum IDLE/LOAD/RUN/CAPTURE;
  - the `WIDTH` and `ITER` defaults;
  - `MT_SEL_LO`/`MT_SEL_HI` constants, reused by the control unit's decode.
- No sub-module. The HI/LO pair and the counter stay inline.
- The multiplier is instantiated beside this block at the datapath level, not inside it.

## Test plan
- Reset asserted mid-RUN (cycle 10):
  - outputs return to reset values immediately;
  - HI/LO stay 0;
  - `done` never pulses.
- `op_a`=7, `op_b`=6:
  - `mult_ctrl`=1 only in cycle 1;
  - `done` in cycle 35;
  - HI=0, LO=42.
- `op_a`=-3 (0xFFFFFFFD), `op_b`=5: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- `op_a`=`op_b`=0x80000000: HI=0x40000000, LO=0.
- MT write while busy:
  - `mt_we`=1, `mt_sel`=1, `mt_data`=0xDEADBEEF issued in cycle 5;
  - `stall` stays high until cycle 35;
  - the write lands at the edge of cycle 35 once `mt_we` is held, so HI=0xDEADBEEF;
  - an MFLO in cycle 36 returns the product LO.
- Back-to-back starts:
  - `start` held high in the `done` cycle is accepted;
  - the second `done` arrives exactly 35 cycles later;
  - `start` pulses during RUN are ignored.
